// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

  // Next-PC source, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    SelSeq,
    SelBranch,
    SelJump,
    SelJr
  } npc_sel_e;

endpackage

// File: rtl/fetch_unit_if_id_register.sv
// IF/ID pipeline register. A flush inserts a bubble and overrides stall.
module if_id_register
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc4_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc4_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc4_q;
  logic                  valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= DATA_WIDTH'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= DATA_WIDTH'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, fault tracking and IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE    = DEFAULT_TEXT_BASE,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  branch_taken_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  jump_i,
  input  logic [25:0]           jump_index_i,
  input  logic                  jr_i,
  input  logic [DATA_WIDTH-1:0] jr_target_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic [DATA_WIDTH-1:0] rom_addr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic [DATA_WIDTH-1:0] if_id_pc4_o,
  output logic                  if_id_valid_o,
  output logic                  fetch_fault_o
);

  localparam logic [DATA_WIDTH-1:0] Base     = DATA_WIDTH'(TEXT_BASE);
  localparam logic [DATA_WIDTH-1:0] MemBytes = DATA_WIDTH'(MEMORY_DEPTH * 4);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4, npc, npc_off;
  logic                  fault_q, fault_d;
  logic                  redirect, hold, npc_bad;
  npc_sel_e              sel;

  always_comb begin
    sel = SelSeq;
    if (jr_i)                sel = SelJr;
    else if (jump_i)         sel = SelJump;
    else if (branch_taken_i) sel = SelBranch;
  end

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);
  assign redirect = jr_i | jump_i | branch_taken_i;
  // A redirect must never be lost, so it overrides the hazard stall.
  assign hold     = stall_i & ~redirect;

  always_comb begin
    npc = pc_plus4;
    unique case (sel)
      SelSeq:    npc = pc_plus4;
      SelBranch: npc = branch_target_i;
      SelJump:   npc = {if_id_pc4_o[DATA_WIDTH-1 -: 4], jump_index_i, 2'b00};
      SelJr:     npc = jr_target_i;
    endcase
  end

  assign npc_off = npc - Base;
  assign npc_bad = (npc[1:0] != 2'b00) || (npc < Base) || (npc_off >= MemBytes);

  always_comb begin
    pc_d    = hold ? pc_q : {npc[DATA_WIDTH-1:2], 2'b00};
    fault_d = fault_q | (~hold & npc_bad);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= Base;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc_o          = pc_q;
  assign rom_addr_o    = pc_q - Base;
  assign fetch_fault_o = fault_q;

  if_id_register #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .stall_i (hold),
    .flush_i (flush_i),
    .instr_i (instr_i),
    .pc4_i   (pc_plus4),
    .instr_o (if_id_instr_o),
    .pc4_o   (if_id_pc4_o),
    .valid_o (if_id_valid_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; ROM word k holds 32'h1000_0000 + k, beyond 64 words reads DEADBEEF.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, branch_taken_i, jump_i, jr_i;
  logic [31:0] branch_target_i, jr_target_i, instr_i;
  logic [25:0] jump_index_i;
  logic [31:0] rom_addr_o, pc_o, if_id_instr_o, if_id_pc4_o;
  logic        if_id_valid_o, fetch_fault_o;

  int checks = 0;
  int passed = 0;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .instr_i         (instr_i),
    .rom_addr_o      (rom_addr_o),
    .pc_o            (pc_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_valid_o   (if_id_valid_o),
    .fetch_fault_o   (fetch_fault_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (rom_addr_o[31:2] < 30'd64) instr_i = 32'h1000_0000 + {2'b00, rom_addr_o[31:2]};
    else                           instr_i = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0; jr_i = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #2;
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    branch_target_i = '0; jr_target_i = '0; jump_index_i = '0;
    #3;
    chk("rst_pc", pc_o, 32'h0040_0000);
    chk("rst_rom_addr", rom_addr_o, 32'h0);
    chk("rst_instr", if_id_instr_o, 32'h0);
    chk("rst_pc4", if_id_pc4_o, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault_o}, 32'h0);
    @(posedge clk); #1;
    reset = 0;

    // Free-running A, B
    step();
    chk("a_instr", if_id_instr_o, 32'h1000_0000);
    chk("a_pc4", if_id_pc4_o, 32'h0040_0004);
    chk("a_valid", {31'b0, if_id_valid_o}, 32'h1);
    step();
    chk("b_instr", if_id_instr_o, 32'h1000_0001);
    chk("b_pc", pc_o, 32'h0040_0008);

    // Two stall cycles at 0x00400008
    stall_i = 1;
    step();
    chk("stall1_pc", pc_o, 32'h0040_0008);
    chk("stall1_instr", if_id_instr_o, 32'h1000_0001);
    step();
    chk("stall2_pc", pc_o, 32'h0040_0008);
    chk("stall2_pc4", if_id_pc4_o, 32'h0040_0008);
    stall_i = 0;
    step();
    chk("c_instr", if_id_instr_o, 32'h1000_0002);
    chk("c_pc4", if_id_pc4_o, 32'h0040_000C);
    step();
    chk("d_instr", if_id_instr_o, 32'h1000_0003);
    chk("d_pc4", if_id_pc4_o, 32'h0040_0010);
    chk("d_pc", pc_o, 32'h0040_0010);

    // Taken branch with flush
    branch_taken_i = 1; branch_target_i = 32'h0040_0020; flush_i = 1;
    step();
    chk("br_pc", pc_o, 32'h0040_0020);
    chk("br_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("br_instr", if_id_instr_o, 32'h0);
    chk("br_pc4", if_id_pc4_o, 32'h0);
    idle();
    step();
    chk("br_fetch_instr", if_id_instr_o, 32'h1000_0008);
    chk("br_fetch_pc4", if_id_pc4_o, 32'h0040_0024);

    // jr beats branch and stall
    jr_i = 1; jr_target_i = 32'h0040_0040; branch_taken_i = 1; stall_i = 1;
    step();
    chk("jr_pc", pc_o, 32'h0040_0040);
    chk("jr_rom_addr", rom_addr_o, 32'h0000_0040);
    idle();
    step();
    chk("jr_fetch_instr", if_id_instr_o, 32'h1000_0010);
    chk("jr_fault", {31'b0, fetch_fault_o}, 32'h0);

    // Flush wins over stall; PC holds
    stall_i = 1; flush_i = 1;
    step();
    chk("flst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("flst_pc", pc_o, 32'h0040_0044);
    idle();

    // Misaligned jr target
    jr_i = 1; jr_target_i = 32'h0040_0102;
    step();
    chk("mis_pc", pc_o, 32'h0040_0100);
    chk("mis_fault", {31'b0, fetch_fault_o}, 32'h1);
    idle();
    step();
    chk("mis_sticky", {31'b0, fetch_fault_o}, 32'h1);
    chk("mis_fetch_instr", if_id_instr_o, 32'hDEAD_BEEF);
    chk("mis_fetch_valid", {31'b0, if_id_valid_o}, 32'h1);

    // Async reset in the middle of a stall
    stall_i = 1; reset = 1;
    #1;
    chk("arst_pc", pc_o, 32'h0040_0000);
    chk("arst_fault", {31'b0, fetch_fault_o}, 32'h0);
    chk("arst_valid", {31'b0, if_id_valid_o}, 32'h0);
    #1;
    reset = 0; stall_i = 0;

    // Target exactly one past the end of memory; fetched instr still enters IF/ID
    jr_i = 1; jr_target_i = 32'h0040_0100;
    step();
    chk("oor_pc", pc_o, 32'h0040_0100);
    chk("oor_fault", {31'b0, fetch_fault_o}, 32'h1);
    chk("oor_instr", if_id_instr_o, 32'h1000_0000);
    idle();

    // Below TEXT_BASE
    do_reset();
    jr_i = 1; jr_target_i = 32'h003F_FFFC;
    step();
    chk("low_pc", pc_o, 32'h003F_FFFC);
    chk("low_rom_addr", rom_addr_o, 32'hFFFF_FFFC);
    chk("low_fault", {31'b0, fetch_fault_o}, 32'h1);
    idle();

    // Last word in range is fine; running past it faults
    do_reset();
    jr_i = 1; jr_target_i = 32'h0040_00FC;
    step();
    chk("last_pc", pc_o, 32'h0040_00FC);
    chk("last_fault", {31'b0, fetch_fault_o}, 32'h0);
    idle();
    step();
    chk("runoff_pc", pc_o, 32'h0040_0100);
    chk("runoff_fault", {31'b0, fetch_fault_o}, 32'h1);

    // Jump using pc4 of the instruction in ID
    do_reset();
    for (int i = 0; i < 4; i++) step();
    chk("pre_jmp_pc4", if_id_pc4_o, 32'h0040_0010);
    jump_i = 1; jump_index_i = 26'h010_0100; branch_taken_i = 1;
    branch_target_i = 32'h0040_0020;
    step();
    chk("jmp_pc", pc_o, 32'h0040_0400);
    chk("jmp_fault", {31'b0, fetch_fault_o}, 32'h1);
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue MIPS core. It sits directly upstream of the program memory: it owns the program counter, drives the ROM's byte address, and captures the returned instruction into the IF/ID pipeline register for the decode stage. It also resolves next-PC selection (sequential, branch, jump, jump-register), stalls, and flushes.

## Interface
- TEXT_BASE, 32'h0040_0000, byte address of the first instruction; the PC reset value.
- MEMORY_DEPTH, 64, program memory depth in words; used for fault detection.
- DATA_WIDTH, 32, instruction and address width.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard unit: hold PC and IF/ID.
- flush_i  in  1  squash IF/ID (bubble) on next edge.
- branch_taken_i  in  1  branch resolved taken in ID.
- branch_target_i  in  32  branch target byte address.
- jump_i  in  1  J/JAL in ID.
- jump_index_i  in  26  J-format instruction index.
- jr_i  in  1  JR/JALR in ID.
- jr_target_i  in  32  register target.
- instr_i  in  32  combinational ROM data for rom_addr_o.
- rom_addr_o  out  32  byte offset into program memory, PC − TEXT_BASE.
- pc_o  out  32  current PC.
- if_id_instr_o  out  32  latched instruction.
- if_id_pc4_o  out  32  latched PC+4.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- fetch_fault_o  out  1  sticky: misaligned or out-of-range fetch.

## Operation
- Next-PC priority: jr_i > jump_i > branch_taken_i > PC+4.
- Jump target: {PC+4[31:28], jump_index_i, 2'b00}, using the PC+4 of the instruction in ID (if_id_pc4_o).
- Redirect (any of jr/jump/branch) loads PC even when stall_i=1; redirect is never dropped.
- stall_i=1 without redirect: PC and IF/ID hold.
- flush_i=1: IF/ID loads instr 32'h0000_0000, pc4 0, valid 0, regardless of stall_i.
- Otherwise IF/ID loads instr_i, PC+4, valid 1.
- rom_addr_o = PC − TEXT_BASE, combinational from PC register.
- Fault: the next PC has [1:0]≠0, or (next PC − TEXT_BASE) ≥ MEMORY_DEPTH*4, or next PC < TEXT_BASE → PC loads with bits [1:0] forced to 00, fetch_fault_o sets and stays set until reset. The faulting fetch still proceeds; no stall is generated internally.
- All arithmetic is modulo 2^32; PC+4 wraps silently.

## Timing
- Reset (async): PC=TEXT_BASE, if_id_instr_o=0, if_id_pc4_o=0, if_id_valid_o=0, fetch_fault_o=0; rom_addr_o=0 combinationally.
- First edge after reset release: IF/ID captures instr_i at offset 0 and pc4=TEXT_BASE+4; PC=TEXT_BASE+4.
- Fetch latency: 1 cycle from PC to IF/ID.
- Redirect penalty: the instruction fetched in the redirect cycle enters IF/ID. The hazard unit asserts flush_i in the same cycle to squash it; the block does not squash it implicitly.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately.

## Structure
- Shared package: TEXT_BASE default, NOP_INSTR=32'h0, next-PC select encoding.
- One sub-module: if_id_register, which holds instr/pc4/valid with stall and flush inputs. The PC register and next-PC mux live in fetch_unit.

## Test plan
- Reset then 4 free-running cycles, ROM words A,B,C,D → IF/ID shows A..D with pc4 0x00400004..0x00400010, valid=1.
- stall_i high for 2 cycles at PC 0x00400008 → pc_o and IF/ID unchanged for 2 cycles, then resume with C.
- branch_taken_i=1, target 0x00400020, flush_i=1 in the same cycle → next pc_o=0x00400020, IF/ID valid=0, instr=0.
- jr_i and branch_taken_i together with stall_i=1, jr_target 0x00400040 → pc_o=0x00400040 (jr wins, stall ignored for PC).
- jump_i with index 0x0100100, pc4 0x00400010 → pc_o=0x00400400.
- jr_target 0x00400102 → pc_o=0x00400100 and fetch_fault_o=1 until reset; separately, target 0x00400100 with MEMORY_DEPTH=64 → fault.
